// File: rtl/multisymbol_pkg.sv
// Shared defaults, symbol type and FSM encoding for the multi-symbol carry resolver.
package multisymbol_pkg;

  localparam int DEF_NUMSYMBOLS        = 32;
  localparam int DEF_LOGRADIX          = 33;
  localparam int DEF_SYMBOLBITWIDTH    = 34;
  localparam int DEF_SYMBOLS_PER_CYCLE = 4;
  localparam int DEF_AUXBITWIDTH       = 8;

  typedef logic signed [DEF_SYMBOLBITWIDTH-1:0] symbol_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/multisymbol_carry_step.sv
// Combinational carry resolution of one group of signed symbols.
// Symbol 0 of the group is least significant; the carry ripples upward through the group.
module multisymbol_carry_step #(
  parameter int LOGRADIX          = 33,
  parameter int SYMBOLBITWIDTH    = 34,
  parameter int SYMBOLS_PER_CYCLE = 4,
  parameter int CARRYW            = SYMBOLBITWIDTH + 2 - LOGRADIX
) (
  input  logic [CARRYW-1:0]                                carry_i,
  input  logic [SYMBOLS_PER_CYCLE-1:0][SYMBOLBITWIDTH-1:0] syms_i,
  output logic [SYMBOLS_PER_CYCLE*LOGRADIX-1:0]            digits_o,
  output logic [CARRYW-1:0]                                carry_o
);

  localparam int TW = SYMBOLBITWIDTH + 2;

  logic [TW-1:0]     t;
  logic [CARRYW-1:0] c;

  // Ripple the carry through the group: t = carry + sext(sym), keep the low digit,
  // and the upper bits of t are the arithmetic shift t >>> LOGRADIX.
  always_comb begin
    digits_o = '0;
    t        = '0;
    c        = carry_i;
    for (int k = 0; k < SYMBOLS_PER_CYCLE; k++) begin
      t = {{(TW-CARRYW){c[CARRYW-1]}}, c}
        + {{(TW-SYMBOLBITWIDTH){syms_i[k][SYMBOLBITWIDTH-1]}}, syms_i[k]};
      digits_o[k*LOGRADIX +: LOGRADIX] = t[LOGRADIX-1:0];
      c = t[TW-1:LOGRADIX];
    end
    carry_o = c;
  end

endmodule

// File: rtl/multisymbol_carry_resolver.sv
// Sequential normaliser: turns a redundant signed multi-symbol operand into plain
// two's-complement binary, SYMBOLS_PER_CYCLE symbols per clock, plus a signed aux word
// holding floor(value / 2^OUTPUTBITWIDTH).
module multisymbol_carry_resolver
  import multisymbol_pkg::*;
#(
  parameter int NUMSYMBOLS        = DEF_NUMSYMBOLS,
  parameter int LOGRADIX          = DEF_LOGRADIX,
  parameter int SYMBOLBITWIDTH    = DEF_SYMBOLBITWIDTH,
  parameter int SYMBOLS_PER_CYCLE = DEF_SYMBOLS_PER_CYCLE,
  parameter int AUXBITWIDTH       = DEF_AUXBITWIDTH,
  parameter int OUTPUTBITWIDTH    = NUMSYMBOLS * LOGRADIX
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [NUMSYMBOLS-1:0][SYMBOLBITWIDTH-1:0]  data_in,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [OUTPUTBITWIDTH-1:0]                  data_out,
  output logic [AUXBITWIDTH-1:0]                     dataaux_out
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready=1
  // RUN   | resolving one symbol group per cycle, LS group first
  // DONE  | result presented, held until out_ready

  localparam int NSTEPS = NUMSYMBOLS / SYMBOLS_PER_CYCLE;
  localparam int STEPW  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam int CARRYW = SYMBOLBITWIDTH + 2 - LOGRADIX;
  localparam int SLICEW = SYMBOLS_PER_CYCLE * LOGRADIX;
  localparam int CHUNKW = SYMBOLS_PER_CYCLE * SYMBOLBITWIDTH;

  state_e                                    state_q, state_d;
  logic [STEPW-1:0]                          step_q, step_d;
  logic [CARRYW-1:0]                         carry_q, carry_d;
  logic [NUMSYMBOLS-1:0][SYMBOLBITWIDTH-1:0] sym_q, sym_d;
  logic [OUTPUTBITWIDTH-1:0]                 dout_q, dout_d;
  logic [AUXBITWIDTH-1:0]                    aux_q, aux_d;

  logic [SLICEW-1:0]      slice;
  logic [CARRYW-1:0]      carry_step;
  logic [AUXBITWIDTH-1:0] aux_ext;

  multisymbol_carry_step #(
    .LOGRADIX          (LOGRADIX),
    .SYMBOLBITWIDTH    (SYMBOLBITWIDTH),
    .SYMBOLS_PER_CYCLE (SYMBOLS_PER_CYCLE),
    .CARRYW            (CARRYW)
  ) u_step (
    .carry_i  (carry_q),
    .syms_i   (sym_q[SYMBOLS_PER_CYCLE-1:0]),
    .digits_o (slice),
    .carry_o  (carry_step)
  );

  // The aux field is not range-checked: the final carry is sign-extended or truncated.
  if (AUXBITWIDTH > CARRYW) begin : g_aux_sext
    assign aux_ext = {{(AUXBITWIDTH-CARRYW){carry_step[CARRYW-1]}}, carry_step};
  end else begin : g_aux_trunc
    assign aux_ext = carry_step[AUXBITWIDTH-1:0];
  end

  // Next-state and handshake logic; the step counter counts down to a terminal zero.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    carry_d   = carry_q;
    sym_d     = sym_q;
    dout_d    = dout_q;
    aux_d     = aux_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sym_d   = data_in;
          carry_d = '0;
          step_d  = STEPW'(NSTEPS - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        sym_d   = sym_q >> CHUNKW;
        dout_d  = OUTPUTBITWIDTH'({slice, dout_q} >> SLICEW);
        carry_d = carry_step;
        step_d  = step_q - STEPW'(1);
        if (step_q == '0) begin
          aux_d   = aux_ext;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; a reset drops any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      carry_q <= '0;
      sym_q   <= '0;
      dout_q  <= '0;
      aux_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      carry_q <= carry_d;
      sym_q   <= sym_d;
      dout_q  <= dout_d;
      aux_q   <= aux_d;
    end
  end

  assign data_out    = dout_q;
  assign dataaux_out = aux_q;

endmodule

// File: tb/tb_multisymbol_carry_resolver.sv
// Self-checking bench for multisymbol_carry_resolver against a big-integer value model.
module tb_multisymbol_carry_resolver;

  localparam int NS     = 32;
  localparam int LR     = 33;
  localparam int SW     = 34;
  localparam int SPC    = 4;
  localparam int AW     = 8;
  localparam int OW     = NS * LR;
  localparam int VW     = OW + 24;
  localparam int CW     = OW / 4;
  localparam int NSTEPS = NS / SPC;

  typedef logic [NS-1:0][SW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  vec_t          data_in;
  logic [OW-1:0] data_out;
  logic [AW-1:0] dataaux_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multisymbol_carry_resolver #(
    .NUMSYMBOLS        (NS),
    .LOGRADIX          (LR),
    .SYMBOLBITWIDTH    (SW),
    .SYMBOLS_PER_CYCLE (SPC),
    .AUXBITWIDTH       (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .dataaux_out (dataaux_out)
  );

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [OW-1:0] exp_d, input logic [AW-1:0] exp_a);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s data[%0d]", tag, k), data_out[k*CW +: CW], exp_d[k*CW +: CW]);
    check({tag, " aux"}, CW'(dataaux_out), CW'(exp_a));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // value = sum sext(sym[i]) * 2^(i*LR), kept wide enough that bits above OW are floor(value/2^OW).
  function automatic logic [VW-1:0] model_value(input vec_t s);
    logic [VW-1:0] acc, term;
    acc = '0;
    for (int i = 0; i < NS; i++) begin
      term = {{(VW-SW){s[i][SW-1]}}, s[i]};
      acc  = acc + (term << (i * LR));
    end
    return acc;
  endfunction

  // mode 0: uniform symbols; mode 1: mix of uniform and extreme values.
  function automatic vec_t rand_syms(input int mode);
    vec_t        v;
    logic [63:0] r;
    for (int i = 0; i < NS; i++) begin
      r = {$urandom, $urandom};
      case ((mode == 1) ? $urandom_range(0, 3) : 0)
        1:       v[i] = {1'b1, {(SW-1){1'b0}}};
        2:       v[i] = {1'b0, {(SW-1){1'b1}}};
        3:       v[i] = '1;
        default: v[i] = r[SW-1:0];
      endcase
    end
    return v;
  endfunction

  // Digits of x, each negated into a signed symbol.
  function automatic vec_t neg_syms(input logic [OW-1:0] x);
    vec_t v;
    for (int i = 0; i < NS; i++)
      v[i] = SW'(0) - {{(SW-LR){1'b0}}, x[i*LR +: LR]};
    return v;
  endfunction

  task automatic wait_valid(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, CW'(lat), CW'(NSTEPS + 1));
  endtask

  task automatic run_op(input string tag, input vec_t v, input logic [OW-1:0] exp_d,
                        input logic [AW-1:0] exp_a, input int max_stall);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check({tag, " in_ready"}, CW'(in_ready), CW'(1));
    in_valid = 1'b1;
    data_in  = v;
    tick();
    in_valid = 1'b0;
    data_in  = rand_syms(0);
    wait_valid(tag);
    repeat ($urandom_range(0, max_stall)) begin
      out_ready = 1'b0;
      tick();
    end
    check_result(tag, exp_d, exp_a);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, CW'(out_valid), CW'(0));
  endtask

  initial begin
    vec_t          v;
    logic [VW-1:0] val;
    logic [OW-1:0] x;
    int            seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset in_ready", CW'(in_ready), CW'(1));
    check("reset out_valid", CW'(out_valid), CW'(0));
    check_result("reset", '0, '0);

    // all zero
    v = '0;
    run_op("zero", v, '0, '0, 0);

    // -1 in the lowest symbol sign-extends through the whole result
    v    = '0;
    v[0] = '1;
    run_op("minus1", v, '1, 8'hFF, 2);

    // 2^33-1 plus 1 in the next digit: 2^34-1
    v    = '0;
    v[0] = {1'b0, {(SW-1){1'b1}}};
    v[1] = SW'(1);
    run_op("carry1", v, OW'(34'h3_FFFF_FFFF), '0, 1);

    // 0 - x fed as negated digits
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < OW / 32; j++) x[j*32 +: 32] = $urandom;
      run_op("neg", neg_syms(x), OW'(0) - x, (x == '0) ? 8'h00 : 8'hFF, 3);
    end

    // arbitrary signed symbols, including the extremes
    for (int n = 0; n < 200; n++) begin
      v   = rand_syms(1);
      val = model_value(v);
      run_op("mix", v, val[OW-1:0], val[OW+AW-1:OW], 3);
    end

    // backpressure: hold DONE for 20 cycles while in_valid toggles
    v   = rand_syms(1);
    val = model_value(v);
    in_valid = 1'b1;
    data_in  = v;
    tick();
    in_valid = 1'b0;
    wait_valid("bp");
    for (int c = 0; c < 20; c++) begin
      out_ready = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      data_in   = rand_syms(0);
      tick();
      check("bp out_valid", CW'(out_valid), CW'(1));
      check("bp in_ready", CW'(in_ready), CW'(0));
    end
    in_valid = 1'b0;
    check_result("bp", val[OW-1:0], val[OW+AW-1:OW]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    v   = rand_syms(1);
    val = model_value(v);
    run_op("after_bp", v, val[OW-1:0], val[OW+AW-1:OW], 0);

    // reset at RUN step 3 drops the operand
    v = rand_syms(1);
    in_valid = 1'b1;
    data_in  = v;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_run out_valid", CW'(out_valid), CW'(0));
    check("rst_run in_ready", CW'(in_ready), CW'(1));
    out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("rst_run stale", CW'(seen), CW'(0));
    v   = rand_syms(1);
    val = model_value(v);
    run_op("after_rst", v, val[OW-1:0], val[OW+AW-1:OW], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
